aes_round_ctrl: RTL and testbench

//  Parametrised round sequencer for the AES datapath (aes_enc, S_box, key_gen).

---
 rtl/aes_round_ctrl.sv | 175 +++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: round sequencer for the AES datapath (aes_enc, S_box, key_gen).
// Sequences AESENC / AESENCLAST / AESENCFULL / AESKEYGENASSIST for AES-128/256.
// Optional build macro AES_ROUND_CTRL_ABORT_EN adds an abort_i input that
// returns a busy sequencer to IDLE on the next edge.
package aes_pkg;
    typedef enum logic [2:0] {
        NOOP            = 3'd0,
        AESENC          = 3'd1,
        AESENCLAST      = 3'd2,
        AESENCFULL      = 3'd3,
        AESKEYGENASSIST = 3'd4
    } opcode;
endpackage

module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter  int NK          = 4,
    parameter  int SBOX_CYCLES = 1,
    localparam int NR          = NK + 6,
    localparam int RW          = $clog2(NR + 1)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          start_i,
    input  opcode         opcode_i,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic          abort_i,
`endif
    output logic          busy_o,
    output logic          full_enc_o,
    output logic          final_rnd_o,
    output logic          zero_rnd_o,
    output logic          key_sel_o,
    output logic          key_sub_o,
    output logic          gen_key_o,
    output logic          r_con_ctrl_o,
    output logic          next_rnd_o,
    output logic [RW-1:0] rnd_cnt_o,
    output logic          cipher_ready_o,
    output logic          key_ready_o
);

    if (!(NK == 4 || NK == 8)) begin : g_bad_nk
        $error("aes_round_ctrl: NK must be 4 or 8");
    end
    if (SBOX_CYCLES < 1 || SBOX_CYCLES > 4) begin : g_bad_sbox
        $error("aes_round_ctrl: SBOX_CYCLES must be 1..4");
    end

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ZERO  = 3'd1;
    localparam logic [2:0] S_KSUB  = 3'd2;
    localparam logic [2:0] S_KGEN  = 3'd3;
    localparam logic [2:0] S_SBOX  = 3'd4;
    localparam logic [2:0] S_ROUND = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [1:0]    TLAST  = 2'(SBOX_CYCLES - 1);
    localparam logic [RW-1:0] RLAST  = RW'(NR);

    logic [2:0]    state;
    opcode         op;
    logic [RW-1:0] rnd_cnt;
    logic [1:0]    tmr;
    logic          tmr_done;
    logic          op_valid;

    assign tmr_done = (tmr == TLAST);
    assign op_valid = opcode_i inside {AESENC, AESENCLAST, AESENCFULL, AESKEYGENASSIST};

    // State, latched opcode, round counter and S-box dwell timer
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= S_IDLE;
            op      <= NOOP;
            rnd_cnt <= '0;
            tmr     <= '0;
        end else begin
`ifdef AES_ROUND_CTRL_ABORT_EN
            if (abort_i && state != S_IDLE) begin
                state   <= S_IDLE;
                op      <= NOOP;
                rnd_cnt <= '0;
                tmr     <= '0;
            end else begin
`else
            begin
`endif
                case (state)
                    S_IDLE: if (start_i && op_valid) begin
                        op      <= opcode_i;
                        rnd_cnt <= '0;
                        tmr     <= '0;
                        case (opcode_i)
                            AESENCFULL:      state <= S_ZERO;
                            AESKEYGENASSIST: state <= S_KSUB;
                            default:         state <= S_SBOX;
                        endcase
                    end
                    S_ZERO: begin
                        rnd_cnt <= rnd_cnt + 1'b1;
                        state   <= S_KSUB;
                    end
                    S_KSUB: if (tmr_done) begin
                        tmr   <= '0;
                        state <= S_KGEN;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                    S_KGEN: state <= (op == AESKEYGENASSIST) ? S_DONE : S_SBOX;
                    S_SBOX: if (tmr_done) begin
                        tmr   <= '0;
                        state <= S_ROUND;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                    S_ROUND: if (op == AESENCFULL && rnd_cnt != RLAST) begin
                        rnd_cnt <= rnd_cnt + 1'b1;
                        state   <= S_KSUB;
                    end else begin
                        state <= S_DONE;
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Moore output decode from registered state/op/round only
    always_comb begin
        busy_o         = (state != S_IDLE);
        full_enc_o     = 1'b0;
        final_rnd_o    = 1'b0;
        zero_rnd_o     = 1'b0;
        key_sel_o      = 1'b0;
        key_sub_o      = 1'b0;
        gen_key_o      = 1'b0;
        r_con_ctrl_o   = 1'b0;
        next_rnd_o     = 1'b0;
        cipher_ready_o = 1'b0;
        key_ready_o    = 1'b0;
        case (state)
            S_ZERO: zero_rnd_o = 1'b1;
            S_KSUB: key_sub_o  = 1'b1;
            S_KGEN: begin
                gen_key_o = 1'b1;
                // AES-256 alternates RotWord+Rcon (odd rounds) with SubWord-only
                if (op == AESKEYGENASSIST || NK == 4) r_con_ctrl_o = 1'b1;
                else                                  r_con_ctrl_o = rnd_cnt[0];
            end
            S_ROUND: begin
                if (op == AESENCFULL) begin
                    key_sel_o   = 1'b1;
                    next_rnd_o  = 1'b1;
                    full_enc_o  = (rnd_cnt < RLAST);
                    final_rnd_o = (rnd_cnt == RLAST);
                end else if (op == AESENCLAST) begin
                    final_rnd_o = 1'b1;
                end else begin
                    full_enc_o = 1'b1;
                end
            end
            S_DONE: begin
                key_ready_o    = (op == AESKEYGENASSIST);
                cipher_ready_o = (op != AESKEYGENASSIST);
            end
            default: ;
        endcase
    end

    assign rnd_cnt_o = rnd_cnt;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: table-driven checks of aes_round_ctrl for NK=4/SBOX_CYCLES=1
// and NK=8/SBOX_CYCLES=2, plus hand sequences for ignored starts, back-to-back
// accepts, mid-operation reset and (when AES_ROUND_CTRL_ABORT_EN) abort.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    logic       clk = 1'b0;
    logic       nrst;
    logic [1:0] start_v;
    opcode      opc;
    logic       abort;

    typedef struct packed {
        logic busy, full, fin, zero, ksel, ksub, gen, rcon, nxt, crdy, krdy;
        logic [3:0] rnd;
    } obs_t;

    obs_t o4, o8;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NK(4), .SBOX_CYCLES(1)) dut4 (
        .clk(clk), .nrst(nrst), .start_i(start_v[0]), .opcode_i(opc),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .abort_i(abort),
`endif
        .busy_o(o4.busy), .full_enc_o(o4.full), .final_rnd_o(o4.fin),
        .zero_rnd_o(o4.zero), .key_sel_o(o4.ksel), .key_sub_o(o4.ksub),
        .gen_key_o(o4.gen), .r_con_ctrl_o(o4.rcon), .next_rnd_o(o4.nxt),
        .rnd_cnt_o(o4.rnd), .cipher_ready_o(o4.crdy), .key_ready_o(o4.krdy)
    );

    aes_round_ctrl #(.NK(8), .SBOX_CYCLES(2)) dut8 (
        .clk(clk), .nrst(nrst), .start_i(start_v[1]), .opcode_i(opc),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .abort_i(abort),
`endif
        .busy_o(o8.busy), .full_enc_o(o8.full), .final_rnd_o(o8.fin),
        .zero_rnd_o(o8.zero), .key_sel_o(o8.ksel), .key_sub_o(o8.ksub),
        .gen_key_o(o8.gen), .r_con_ctrl_o(o8.rcon), .next_rnd_o(o8.nxt),
        .rnd_cnt_o(o8.rnd), .cipher_ready_o(o8.crdy), .key_ready_o(o8.krdy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic obs_t get(input int sel);
        return (sel == 0) ? o4 : o8;
    endfunction

    typedef struct {
        int    sel;
        opcode op;
        int    inj;      // round at which an AESENC start is injected (0 = none)
        int    bound;
        int    rdy_cyc;
        int    n_crdy, n_krdy, n_zero, n_full, n_fin, n_rcon, n_ksub, n_gen, n_nxt, n_busy;
        int    fin_cnt;  // rnd_cnt seen while final_rnd_o high (-1 = never)
        int    end_cnt;
    } vec_t;

    vec_t vecs[9];

    // Runs one operation on the selected instance and checks every tally
    task automatic apply_vec(input vec_t v, input string tag);
        obs_t o;
        int cyc = 1, rdy = -1, fc = -1;
        int c_crdy = 0, c_krdy = 0, c_zero = 0, c_full = 0, c_fin = 0, c_rcon = 0;
        int c_ksub = 0, c_gen = 0, c_nxt = 0, c_busy = 0, c_ksel = 0;
        bit injected = 0, inj_clear = 0, done = 0;
        @(negedge clk);
        opc = v.op;
        start_v[v.sel] = 1'b1;
        @(negedge clk);
        start_v[v.sel] = 1'b0;
        while (cyc <= v.bound && !done) begin
            o = get(v.sel);
            if (!o.busy) done = 1;
            else begin
                c_busy++;
                if (o.crdy) c_crdy++;
                if (o.krdy) c_krdy++;
                if ((o.crdy || o.krdy) && rdy < 0) rdy = cyc;
                if (o.zero) c_zero++;
                if (o.full) c_full++;
                if (o.fin) begin c_fin++; fc = int'(o.rnd); end
                if (o.rcon) c_rcon++;
                if (o.ksub) c_ksub++;
                if (o.gen)  c_gen++;
                if (o.nxt)  c_nxt++;
                if (o.ksel) c_ksel++;
                if (inj_clear) begin start_v[v.sel] = 1'b0; inj_clear = 0; end
                if (v.inj != 0 && !injected && int'(o.rnd) == v.inj && o.full) begin
                    opc = AESENC;
                    start_v[v.sel] = 1'b1;
                    injected = 1;
                    inj_clear = 1;
                end
                cyc++;
                @(negedge clk);
            end
        end
        start_v[v.sel] = 1'b0;
        chk({tag, " completed"}, int'(done), 1);
        chk({tag, " ready_cycle"}, rdy, v.rdy_cyc);
        chk({tag, " cipher_ready"}, c_crdy, v.n_crdy);
        chk({tag, " key_ready"}, c_krdy, v.n_krdy);
        chk({tag, " zero_rnd"}, c_zero, v.n_zero);
        chk({tag, " full_enc"}, c_full, v.n_full);
        chk({tag, " final_rnd"}, c_fin, v.n_fin);
        chk({tag, " r_con_ctrl"}, c_rcon, v.n_rcon);
        chk({tag, " key_sub"}, c_ksub, v.n_ksub);
        chk({tag, " gen_key"}, c_gen, v.n_gen);
        chk({tag, " next_rnd"}, c_nxt, v.n_nxt);
        chk({tag, " key_sel"}, c_ksel, v.n_nxt);
        chk({tag, " busy_cycles"}, c_busy, v.n_busy);
        chk({tag, " final_at_cnt"}, fc, v.fin_cnt);
        chk({tag, " end_rnd_cnt"}, int'(get(v.sel).rnd), v.end_cnt);
    endtask

    initial begin
        obs_t o;
        int r1, r2, cyc, seen;
        // sel op inj bound rdy crdy krdy zero full fin rcon ksub gen nxt busy fincnt endcnt
        vecs[0] = '{0, AESENC,          0, 20,  3, 1, 0, 0,  1, 0,  0,  0,  0,  0,  3, -1,  0};
        vecs[1] = '{0, AESENCLAST,      0, 20,  3, 1, 0, 0,  0, 1,  0,  0,  0,  0,  3,  0,  0};
        vecs[2] = '{0, AESENCFULL,      0, 80, 42, 1, 0, 1,  9, 1, 10, 10, 10, 10, 42, 10, 10};
        vecs[3] = '{0, AESKEYGENASSIST, 0, 20,  3, 0, 1, 0,  0, 0,  1,  1,  1,  0,  3, -1,  0};
        vecs[4] = '{1, AESENCFULL,      0, 150, 86, 1, 0, 1, 13, 1,  7, 28, 14, 14, 86, 14, 14};
        vecs[5] = '{1, AESENC,          0, 20,  4, 1, 0, 0,  1, 0,  0,  0,  0,  0,  4, -1,  0};
        vecs[6] = '{1, AESKEYGENASSIST, 0, 20,  4, 0, 1, 0,  0, 0,  1,  2,  1,  0,  4, -1,  0};
        vecs[7] = '{1, AESENCLAST,      0, 20,  4, 1, 0, 0,  0, 1,  0,  0,  0,  0,  4,  0,  0};
        vecs[8] = '{0, AESENCFULL,      5, 80, 42, 1, 0, 1,  9, 1, 10, 10, 10, 10, 42, 10, 10};

        nrst = 1'b0; start_v = '0; opc = NOOP; abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset outputs dut4", int'(o4), 0);
        chk("reset outputs dut8", int'(o8), 0);
        nrst = 1'b1;

        for (int i = 0; i < 9; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // NOOP and unknown opcode with start in IDLE: ignored, rnd_cnt kept
        @(negedge clk);
        opc = NOOP; start_v[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("noop busy", int'(o4.busy), 0);
            chk("noop rnd_cnt", int'(o4.rnd), 10);
        end
        opc = opcode'(3'd6);
        @(negedge clk);
        chk("unknown op busy", int'(o4.busy), 0);
        chk("unknown op rnd_cnt", int'(o4.rnd), 10);
        start_v[0] = 1'b0;

        // Back-to-back: start held high, second accept the cycle after DONE
        @(negedge clk);
        opc = AESENC; start_v[0] = 1'b1;
        r1 = -1; r2 = -1; seen = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (o4.crdy) begin
                if (r1 < 0) r1 = c; else r2 = c;
            end
            if (c == 4) chk("b2b idle gap busy", int'(o4.busy), 0);
            if (c == 8) start_v[0] = 1'b0;
        end
        chk("b2b first ready", r1, 3);
        chk("b2b second ready", r2, 7);
        @(negedge clk);
        chk("b2b returns idle", int'(o4.busy), 0);

        // Reset during round 3 of AESENCFULL
        opc = AESENCFULL; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        cyc = 0;
        while (!(o4.rnd == 4'd3 && o4.full) && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach round 3", int'(cyc < 60), 1);
        nrst = 1'b0;
        #1;
        chk("mid reset outputs", int'(o4), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (o4.crdy || o4.krdy) seen++;
        end
        nrst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (o4.crdy || o4.krdy || o4.busy) seen++;
        end
        chk("no activity after reset", seen, 0);
        apply_vec(vecs[0], "post_reset_enc");

`ifdef AES_ROUND_CTRL_ABORT_EN
        // Abort in round 3 wins over a simultaneous start
        @(negedge clk);
        opc = AESENCFULL; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        cyc = 0;
        while (!(o4.rnd == 4'd3 && o4.full) && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort reach round 3", int'(cyc < 60), 1);
        abort = 1'b1; opc = AESENC; start_v[0] = 1'b1;
        @(negedge clk);
        abort = 1'b0; start_v[0] = 1'b0;
        chk("abort outputs", int'(o4), 0);
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (o4.crdy || o4.busy) seen++;
        end
        chk("abort no ready", seen, 0);
        // Abort in IDLE is ignored: the start still gets accepted
        abort = 1'b1; opc = AESENC; start_v[0] = 1'b1;
        @(negedge clk);
        abort = 1'b0; start_v[0] = 1'b0;
        chk("idle abort ignored", int'(o4.busy), 1);
        repeat (4) @(negedge clk);
        chk("idle abort op finished", int'(o4.busy), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
